// File: rtl/pc_unit_ras.sv
// ---------------------------------------------------------------------------
// pc_unit_ras
// Program counter for the rv32i core. It holds the PC register with a reset
// vector and an update enable, traps on a misaligned jump target, and keeps a
// circular return-address stack (RAS) that predicts JALR returns.
//
// Ports
//   clk          in   1   single clock, rising edge
//   reset        in   1   synchronous, active-high
//   update_pc    in   1   advance PC this cycle (level, sampled at posedge)
//   addr_offset  in   W   branch/JAL immediate
//   alu_result   in   W   JALR target; bit 0 carries the branch condition
//   jump_type    in   3   JUMP_* code (see localparams below)
//   is_call      in   1   JAL/JALR links: push return address
//   is_ret       in   1   JALR is a return: pop
//   pc_current   out  W   current PC (registered)
//   pc_plus_4    out  W   pc_current + 4 (comb)
//   pc_next      out  W   selected target before the alignment check (comb)
//   trap         out  1   high during the single trap cycle (registered)
//   epc          out  W   PC of the faulting instruction (registered)
//   bad_target   out  W   misaligned target that caused the trap (registered)
//   ras_pred     out  W   RAS top entry (comb)
//   ras_valid    out  1   RAS holds at least one entry (comb)
//   ras_mispred  out  1   one-cycle pulse: a valid pop disagreed with the JALR
//                         target (registered)
// ---------------------------------------------------------------------------
module pc_unit_ras #(
    parameter int unsigned              DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]    RESET_VECTOR = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0]    TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned              RAS_DEPTH    = 4,
    parameter int unsigned              ALIGN_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  update_pc,
    input  logic [DATA_WIDTH-1:0] addr_offset,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [2:0]            jump_type,
    input  logic                  is_call,
    input  logic                  is_ret,
    output logic [DATA_WIDTH-1:0] pc_current,
    output logic [DATA_WIDTH-1:0] pc_plus_4,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  trap,
    output logic [DATA_WIDTH-1:0] epc,
    output logic [DATA_WIDTH-1:0] bad_target,
    output logic [DATA_WIDTH-1:0] ras_pred,
    output logic                  ras_valid,
    output logic                  ras_mispred
);

    // Jump-type encoding shared with decode.
    localparam logic [2:0] JUMP_NONE = 3'd0;
    localparam logic [2:0] JUMP_IF_0 = 3'd1;
    localparam logic [2:0] JUMP_IF_1 = 3'd2;
    localparam logic [2:0] JUMP_JAL  = 3'd3;
    localparam logic [2:0] JUMP_JALR = 3'd4;
    localparam logic [2:0] JUMP_ZERO = 3'd5;

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    // Registers and their next-state values
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] bad_q, bad_d;
    logic                  trap_q, trap_d;
    logic                  mispred_q, mispred_d;
    logic [PW-1:0]         top_q, top_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];

    // RAS write port
    logic                  ras_we_s;
    logic [PW-1:0]         ras_widx_s;

    // Datapath helpers
    logic [DATA_WIDTH-1:0] pc_plus_4_s;
    logic [DATA_WIDTH-1:0] pc_rel_s;
    logic [DATA_WIDTH-1:0] jalr_tgt_s;
    logic [DATA_WIDTH-1:0] pc_next_s;
    logic                  misaligned_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  ras_valid_s;

    assign pc_plus_4_s  = pc_q + DATA_WIDTH'(3'd4);
    assign pc_rel_s     = pc_q + addr_offset;
    assign jalr_tgt_s   = {alu_result[DATA_WIDTH-1:1], 1'b0};
    assign misaligned_s = |pc_next_s[ALIGN_BITS-1:0];
    assign ras_valid_s  = (count_q != {CW{1'b0}});

    // Target selection; conditional branches read their outcome from alu bit 0.
    always_comb begin
        pc_next_s = pc_plus_4_s;
        case (jump_type)
            JUMP_IF_0: begin
                if (!alu_result[0]) begin
                    pc_next_s = pc_rel_s;
                end else begin
                    pc_next_s = pc_plus_4_s;
                end
            end
            JUMP_IF_1: begin
                if (alu_result[0]) begin
                    pc_next_s = pc_rel_s;
                end else begin
                    pc_next_s = pc_plus_4_s;
                end
            end
            JUMP_JAL:  pc_next_s = pc_rel_s;
            JUMP_JALR: pc_next_s = jalr_tgt_s;
            JUMP_ZERO: pc_next_s = {DATA_WIDTH{1'b0}};
            JUMP_NONE: pc_next_s = pc_plus_4_s;
            default:   pc_next_s = pc_plus_4_s;
        endcase
    end

    // Only accepted, non-trapping updates in ST_RUN may touch the RAS.
    assign accept_s = (state_q == ST_RUN) && update_pc && !misaligned_s;
    assign push_s   = accept_s && is_call &&
                      ((jump_type == JUMP_JAL) || (jump_type == JUMP_JALR));
    assign pop_s    = accept_s && is_ret && (jump_type == JUMP_JALR);

    // FSM next state, PC and trap capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        bad_d   = bad_q;
        trap_d  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (update_pc && misaligned_s) begin
                    state_d = ST_TRAP;
                    pc_d    = TRAP_VECTOR;
                    epc_d   = pc_q;
                    bad_d   = pc_next_s;
                    trap_d  = 1'b1;
                end else if (update_pc) begin
                    pc_d = pc_next_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // RAS pointer/count update. A simultaneous pop+push replaces the top entry
    // in place; with an empty stack it degenerates to a plain push.
    always_comb begin
        top_d      = top_q;
        count_d    = count_q;
        ras_we_s   = 1'b0;
        ras_widx_s = top_q;
        mispred_d  = 1'b0;
        if (pop_s && ras_valid_s) begin
            mispred_d = (ras_q[top_q] != pc_next_s);
        end else begin
            mispred_d = 1'b0;
        end
        if (push_s && pop_s && ras_valid_s) begin
            ras_we_s   = 1'b1;
            ras_widx_s = top_q;
        end else if (push_s) begin
            // Full stack: the pointer wraps and overwrites the oldest entry.
            ras_we_s   = 1'b1;
            ras_widx_s = top_q + PW'(1'b1);
            top_d      = top_q + PW'(1'b1);
            if (count_q != COUNT_FULL) begin
                count_d = count_q + CW'(1'b1);
            end else begin
                count_d = count_q;
            end
        end else if (pop_s && ras_valid_s) begin
            top_d   = top_q - PW'(1'b1);
            count_d = count_q - CW'(1'b1);
        end else begin
            top_d   = top_q;
            count_d = count_q;
        end
    end

    // State, PC, trap and RAS registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VECTOR;
            epc_q     <= {DATA_WIDTH{1'b0}};
            bad_q     <= {DATA_WIDTH{1'b0}};
            trap_q    <= 1'b0;
            mispred_q <= 1'b0;
            top_q     <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            bad_q     <= bad_d;
            trap_q    <= trap_d;
            mispred_q <= mispred_d;
            top_q     <= top_d;
            count_q   <= count_d;
            if (ras_we_s) begin
                ras_q[ras_widx_s] <= pc_plus_4_s;
            end
        end
    end

    assign pc_current  = pc_q;
    assign pc_plus_4   = pc_plus_4_s;
    assign pc_next     = pc_next_s;
    assign trap        = trap_q;
    assign epc         = epc_q;
    assign bad_target  = bad_q;
    assign ras_pred    = ras_q[top_q];
    assign ras_valid   = ras_valid_s;
    assign ras_mispred = mispred_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;

    localparam logic [2:0] J_NONE = 3'd0;
    localparam logic [2:0] J_IF0  = 3'd1;
    localparam logic [2:0] J_IF1  = 3'd2;
    localparam logic [2:0] J_JAL  = 3'd3;
    localparam logic [2:0] J_JALR = 3'd4;
    localparam logic [2:0] J_ZERO = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        update_pc;
    logic [31:0] addr_offset;
    logic [31:0] alu_result;
    logic [2:0]  jump_type;
    logic        is_call;
    logic        is_ret;
    logic [31:0] pc_current, pc_plus_4, pc_next, epc, bad_target, ras_pred;
    logic        trap, ras_valid, ras_mispred;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit_ras dut (
        .clk         (clk),
        .reset       (reset),
        .update_pc   (update_pc),
        .addr_offset (addr_offset),
        .alu_result  (alu_result),
        .jump_type   (jump_type),
        .is_call     (is_call),
        .is_ret      (is_ret),
        .pc_current  (pc_current),
        .pc_plus_4   (pc_plus_4),
        .pc_next     (pc_next),
        .trap        (trap),
        .epc         (epc),
        .bad_target  (bad_target),
        .ras_pred    (ras_pred),
        .ras_valid   (ras_valid),
        .ras_mispred (ras_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        upd;
        logic [31:0] off;
        logic [31:0] alu;
        logic [2:0]  jt;
        logic        call;
        logic        ret;
        logic [31:0] exp_next;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [31:0] exp_pred;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [30];

    function automatic vec_t mk(logic upd, logic [31:0] off, logic [31:0] alu,
                                logic [2:0] jt, logic call, logic ret,
                                logic [31:0] exp_next, logic [31:0] exp_pc,
                                logic exp_valid, logic [31:0] exp_pred, logic exp_mis);
        vec_t v;
        v.upd = upd; v.off = off; v.alu = alu; v.jt = jt; v.call = call; v.ret = ret;
        v.exp_next = exp_next; v.exp_pc = exp_pc; v.exp_valid = exp_valid;
        v.exp_pred = exp_pred; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic upd, input logic [31:0] off, input logic [31:0] alu,
                         input logic [2:0] jt, input logic call, input logic ret);
        update_pc   = upd;
        addr_offset = off;
        alu_result  = alu;
        jump_type   = jt;
        is_call     = call;
        is_ret      = ret;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pc starts at 0x8 in ST_RUN with an empty RAS
        vecs[0]  = mk(1'b1, 32'h0,        32'h11,   J_JALR, 1'b0, 1'b0, 32'h10,  32'h10,  1'b0, 32'h0,  1'b0);
        vecs[1]  = mk(1'b1, 32'h20,       32'h0,    J_JAL,  1'b0, 1'b0, 32'h30,  32'h30,  1'b0, 32'h0,  1'b0);
        vecs[2]  = mk(1'b1, 32'h100,      32'h1,    J_IF0,  1'b0, 1'b0, 32'h34,  32'h34,  1'b0, 32'h0,  1'b0);
        vecs[3]  = mk(1'b1, 32'h0C,       32'h0,    J_IF0,  1'b0, 1'b0, 32'h40,  32'h40,  1'b0, 32'h0,  1'b0);
        vecs[4]  = mk(1'b1, 32'hFFFFFFC0, 32'h1,    J_IF1,  1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,  1'b0);
        vecs[5]  = mk(1'b1, 32'h100,      32'h0,    J_IF1,  1'b0, 1'b0, 32'h4,   32'h4,   1'b0, 32'h0,  1'b0);
        vecs[6]  = mk(1'b1, 32'h100,      32'h0,    J_ZERO, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,  1'b0);
        // call at 0x0, matching return
        vecs[7]  = mk(1'b1, 32'h200,      32'h0,    J_JAL,  1'b1, 1'b0, 32'h200, 32'h200, 1'b1, 32'h4,  1'b0);
        vecs[8]  = mk(1'b1, 32'h0,        32'h4,    J_JALR, 1'b0, 1'b1, 32'h4,   32'h4,   1'b0, 32'h0,  1'b0);
        vecs[9]  = mk(1'b1, 32'h0,        32'h0,    J_ZERO, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,  1'b0);
        // call at 0x0, return to 0x8: mispredict pulse
        vecs[10] = mk(1'b1, 32'h300,      32'h0,    J_JAL,  1'b1, 1'b0, 32'h300, 32'h300, 1'b1, 32'h4,  1'b0);
        vecs[11] = mk(1'b1, 32'h0,        32'h8,    J_JALR, 1'b0, 1'b1, 32'h8,   32'h8,   1'b0, 32'h0,  1'b1);
        vecs[12] = mk(1'b1, 32'h0,        32'h0,    J_NONE, 1'b0, 1'b0, 32'hC,   32'hC,   1'b0, 32'h0,  1'b0);
        // pop when empty, call flag on a branch, pop+push on empty and non-empty
        vecs[13] = mk(1'b1, 32'h0,        32'h20,   J_JALR, 1'b0, 1'b1, 32'h20,  32'h20,  1'b0, 32'h0,  1'b0);
        vecs[14] = mk(1'b1, 32'h100,      32'h1,    J_IF0,  1'b1, 1'b0, 32'h24,  32'h24,  1'b0, 32'h0,  1'b0);
        vecs[15] = mk(1'b1, 32'h0,        32'h40,   J_JALR, 1'b1, 1'b1, 32'h40,  32'h40,  1'b1, 32'h28, 1'b0);
        vecs[16] = mk(1'b1, 32'h0,        32'h80,   J_JALR, 1'b1, 1'b1, 32'h80,  32'h80,  1'b1, 32'h44, 1'b1);
        vecs[17] = mk(1'b0, 32'h10,       32'h0,    J_JAL,  1'b1, 1'b0, 32'h90,  32'h80,  1'b1, 32'h44, 1'b0);
        vecs[18] = mk(1'b1, 32'h0,        32'h44,   J_JALR, 1'b0, 1'b1, 32'h44,  32'h44,  1'b0, 32'h0,  1'b0);
        // five calls into a 4-deep stack, then pops
        vecs[19] = mk(1'b1, 32'h0,        32'h0,    J_ZERO, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,  1'b0);
        vecs[20] = mk(1'b1, 32'h10,       32'h0,    J_JAL,  1'b1, 1'b0, 32'h10,  32'h10,  1'b1, 32'h4,  1'b0);
        vecs[21] = mk(1'b1, 32'h10,       32'h0,    J_JAL,  1'b1, 1'b0, 32'h20,  32'h20,  1'b1, 32'h14, 1'b0);
        vecs[22] = mk(1'b1, 32'h10,       32'h0,    J_JAL,  1'b1, 1'b0, 32'h30,  32'h30,  1'b1, 32'h24, 1'b0);
        vecs[23] = mk(1'b1, 32'h10,       32'h0,    J_JAL,  1'b1, 1'b0, 32'h40,  32'h40,  1'b1, 32'h34, 1'b0);
        vecs[24] = mk(1'b1, 32'h10,       32'h0,    J_JAL,  1'b1, 1'b0, 32'h50,  32'h50,  1'b1, 32'h44, 1'b0);
        vecs[25] = mk(1'b1, 32'h0,        32'h44,   J_JALR, 1'b0, 1'b1, 32'h44,  32'h44,  1'b1, 32'h34, 1'b0);
        vecs[26] = mk(1'b1, 32'h0,        32'h34,   J_JALR, 1'b0, 1'b1, 32'h34,  32'h34,  1'b1, 32'h24, 1'b0);
        vecs[27] = mk(1'b1, 32'h0,        32'h24,   J_JALR, 1'b0, 1'b1, 32'h24,  32'h24,  1'b1, 32'h14, 1'b0);
        vecs[28] = mk(1'b1, 32'h0,        32'h14,   J_JALR, 1'b0, 1'b1, 32'h14,  32'h14,  1'b0, 32'h0,  1'b0);
        vecs[29] = mk(1'b1, 32'h0,        32'h4,    J_JALR, 1'b0, 1'b1, 32'h4,   32'h4,   1'b0, 32'h0,  1'b0);

        // Reset with update_pc high
        reset = 1'b1;
        drive(1'b1, 32'h0, 32'h0, J_NONE, 1'b0, 1'b0);
        step();
        step();
        check("rst_pc", pc_current, 32'h0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_bad", bad_target, 32'h0);
        check("rst_valid", {31'd0, ras_valid}, 32'd0);
        check("rst_mis", {31'd0, ras_mispred}, 32'd0);
        check("rst_pc4", pc_plus_4, 32'h4);

        // BOOT cycle ignores update_pc, then +4 per cycle
        reset = 1'b0;
        step();
        check("boot_pc", pc_current, 32'h0);
        step();
        check("run_pc1", pc_current, 32'h4);
        step();
        check("run_pc2", pc_current, 32'h8);

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].upd, vecs[i].off, vecs[i].alu, vecs[i].jt, vecs[i].call, vecs[i].ret);
            #1;
            check($sformatf("v%0d_next", i), pc_next, vecs[i].exp_next);
            step();
            check($sformatf("v%0d_pc", i), pc_current, vecs[i].exp_pc);
            check($sformatf("v%0d_trap", i), {31'd0, trap}, 32'd0);
            check($sformatf("v%0d_valid", i), {31'd0, ras_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_pred", i), ras_pred, vecs[i].exp_pred);
            end
            check($sformatf("v%0d_mis", i), {31'd0, ras_mispred}, {31'd0, vecs[i].exp_mis});
        end

        // Misaligned JALR from 0x40 traps and leaves the RAS alone (pc is 0x4 here)
        drive(1'b1, 32'h3C, 32'h0, J_JAL, 1'b1, 1'b0);
        step();
        check("tr_setup_pc", pc_current, 32'h40);
        drive(1'b1, 32'h0, 32'h1002, J_JALR, 1'b0, 1'b1);
        #1;
        check("tr_next", pc_next, 32'h1002);
        step();
        check("tr_trap", {31'd0, trap}, 32'd1);
        check("tr_pc", pc_current, 32'h100);
        check("tr_epc", epc, 32'h40);
        check("tr_bad", bad_target, 32'h1002);
        check("tr_valid", {31'd0, ras_valid}, 32'd1);
        check("tr_pred", ras_pred, 32'h8);
        check("tr_mis", {31'd0, ras_mispred}, 32'd0);
        drive(1'b1, 32'h10, 32'h0, J_JAL, 1'b0, 1'b0);
        step();
        check("tr_hold_trap", {31'd0, trap}, 32'd0);
        check("tr_hold_pc", pc_current, 32'h100);
        step();
        check("tr_resume_pc", pc_current, 32'h110);

        // JAL to 0x112 traps; reset while in the trap state
        drive(1'b1, 32'h2, 32'h0, J_JAL, 1'b0, 1'b0);
        step();
        check("tr2_trap", {31'd0, trap}, 32'd1);
        check("tr2_bad", bad_target, 32'h112);
        check("tr2_epc", epc, 32'h110);
        reset = 1'b1;
        step();
        check("rst2_pc", pc_current, 32'h0);
        check("rst2_trap", {31'd0, trap}, 32'd0);
        check("rst2_epc", epc, 32'h0);
        check("rst2_valid", {31'd0, ras_valid}, 32'd0);

        // update_pc low holds the PC
        reset = 1'b0;
        drive(1'b0, 32'h20, 32'h0, J_JAL, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_pc", i), pc_current, 32'h0);
        end
        drive(1'b1, 32'h20, 32'h0, J_JAL, 1'b0, 1'b0);
        step();
        check("hold_release_pc", pc_current, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
